// File: rtl/data_framer.sv
// ---------------------------------------------------------------------------
// data_framer
//
// Purpose:
//   Builds one output frame per accepted start request:
//     header word 1 : latched op_count
//     header word 2 : latched exp_len
//     body          : payload words {pl_type, pl_data}, one per transfer.
//                     A type-3 "waiting" word 0xC000_0000 is sent on any
//                     body cycle without a transfer.
//   The body ends once op_count type-1 words have been transferred. A single
//   DONE cycle then pulses frame_done and the block returns to IDLE.
//
// Optional feature (compile-time macro DATA_FRAMER_TIMEOUT_EN):
//   An idle counter runs on consecutive body cycles that have no transfer.
//   When it reaches TIMEOUT_CYCLES the frame is aborted. frame_done and
//   frame_err then pulse together. Without the macro, the body waits
//   indefinitely and frame_err is tied to 0.
//
// Ports:
//   clk        in   1  rising-edge clock
//   clear      in   1  synchronous active-low reset
//   start      in   1  frame request, honoured only in IDLE
//   op_count   in  32  number of type-1 words in the frame (latched on start)
//   exp_len    in  32  expected output length (latched on start)
//   pl_data    in  30  payload word
//   pl_type    in   2  0 idle, 1 operation, 2 data chunk, 3 waiting
//   pl_valid   in   1  payload word offered
//   pl_ready   out  1  payload word accepted when high with pl_valid
//   data_out   out 32  registered stream word
//   enable     out  1  registered qualifier for data_out
//   busy       out  1  high whenever the block is not in IDLE
//   frame_done out  1  one-cycle pulse at frame end
//   frame_err  out  1  one-cycle pulse with frame_done on timeout abort
// ---------------------------------------------------------------------------
module data_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] op_count,
  input  logic [31:0] exp_len,
  input  logic [29:0] pl_data,
  input  logic [1:0]  pl_type,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [31:0] data_out,
  output logic        enable,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_OPS = 3'd1,
    HDR_LEN = 3'd2,
    BODY    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0] WAIT_WORD = 32'hC000_0000;

  state_t      state_q, state_d;
  logic [31:0] ops_q, ops_d;
  logic [31:0] len_q, len_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] data_out_q, data_out_d;
  logic        enable_q, enable_d;
  logic        frame_done_q, frame_done_d;

  logic        drained;
  logic        timed_out;
  logic        xfer;

  // All operation words are in. The last word is still on data_out, so
  // the body holds for one more cycle with pl_ready low before DONE.
  assign drained = (cnt_q == ops_q);

`ifdef DATA_FRAMER_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        frame_err_q, frame_err_d;

  assign timed_out = (idle_q >= TIMEOUT_CYCLES);
  assign frame_err = frame_err_q;
`else
  assign timed_out = 1'b0;
  assign frame_err = 1'b0;
`endif

  // pl_ready is gated by clear so that nothing is accepted while in reset.
  assign pl_ready   = (state_q == BODY) && clear && !drained && !timed_out;
  assign xfer       = pl_valid && pl_ready;

  assign data_out   = data_out_q;
  assign enable     = enable_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    ops_d        = ops_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    data_out_d   = 32'd0;
    enable_d     = 1'b0;
    frame_done_d = 1'b0;
`ifdef DATA_FRAMER_TIMEOUT_EN
    idle_d       = idle_q;
    frame_err_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
`ifdef DATA_FRAMER_TIMEOUT_EN
        idle_d = 32'd0;
`endif
        if (start) begin
          ops_d      = op_count;
          len_d      = exp_len;
          // Register the first header now, so that it appears one cycle
          // after the start is accepted.
          data_out_d = op_count;
          enable_d   = 1'b1;
          state_d    = HDR_OPS;
        end
      end

      HDR_OPS: begin
        data_out_d = len_q;
        enable_d   = 1'b1;
        state_d    = HDR_LEN;
      end

      HDR_LEN: begin
        if (ops_q == 32'd0) begin
          frame_done_d = 1'b1;
          state_d      = DONE;
        end else begin
          state_d = BODY;
        end
      end

      BODY: begin
        if (drained || timed_out) begin
          frame_done_d = 1'b1;
`ifdef DATA_FRAMER_TIMEOUT_EN
          frame_err_d  = timed_out;
`endif
          state_d      = DONE;
        end else if (xfer) begin
          data_out_d = {pl_type, pl_data};
          enable_d   = (pl_type != 2'd0);
          if (pl_type == 2'd1) begin
            cnt_d = cnt_q + 32'd1;
          end
`ifdef DATA_FRAMER_TIMEOUT_EN
          idle_d = 32'd0;
`endif
        end else begin
          data_out_d = WAIT_WORD;
          enable_d   = 1'b1;
`ifdef DATA_FRAMER_TIMEOUT_EN
          idle_d = idle_q + 32'd1;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q      <= IDLE;
      ops_q        <= 32'd0;
      len_q        <= 32'd0;
      cnt_q        <= 32'd0;
      data_out_q   <= 32'd0;
      enable_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DATA_FRAMER_TIMEOUT_EN
      idle_q       <= 32'd0;
      frame_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      ops_q        <= ops_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
`ifdef DATA_FRAMER_TIMEOUT_EN
      idle_q       <= idle_d;
      frame_err_q  <= frame_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_framer.sv
// ---------------------------------------------------------------------------
// tb_data_framer
//
// Purpose:
//   Directed testbench for data_framer. It drives hand-written frames and
//   checks every output against hand-computed values. Inputs change 1 time
//   unit after each rising edge, and outputs are sampled at that same point.
//   The timeout scenario is included only when DATA_FRAMER_TIMEOUT_EN is
//   defined.
// ---------------------------------------------------------------------------
module tb_data_framer;

  logic        clk = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] op_count;
  logic [31:0] exp_len;
  logic [29:0] pl_data;
  logic [1:0]  pl_type;
  logic        pl_valid;
  logic        pl_ready;
  logic [31:0] data_out;
  logic        enable;
  logic        busy;
  logic        frame_done;
  logic        frame_err;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  data_framer #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .op_count   (op_count),
    .exp_len    (exp_len),
    .pl_data    (pl_data),
    .pl_type    (pl_type),
    .pl_valid   (pl_valid),
    .pl_ready   (pl_ready),
    .data_out   (data_out),
    .enable     (enable),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Check the registered output word and the status flags.
  task automatic chk_out(input string tag, input logic [31:0] d, input logic en,
                         input logic bz, input logic fd, input logic fe);
    chk({tag, ".data"}, data_out, d);
    chk({tag, ".en"},   {31'd0, enable}, {31'd0, en});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bz});
    chk({tag, ".fd"},   {31'd0, frame_done}, {31'd0, fd});
    chk({tag, ".fe"},   {31'd0, frame_err}, {31'd0, fe});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [29:0] d);
    pl_valid = 1'b1;
    pl_type  = t;
    pl_data  = d;
  endtask

  task automatic no_payload;
    pl_valid = 1'b0;
    pl_type  = 2'd0;
    pl_data  = 30'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear = 1'b0;
    start = 1'b0;
    op_count = 32'd0;
    exp_len = 32'd0;
    no_payload();
    tick();
    tick();

    // Reset state
    chk_out("reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.rdy", {31'd0, pl_ready}, 32'd0);
    clear = 1'b1;
    tick();
    chk_out("idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 1: op_count=2, exp_len=5, three words back to back
    start = 1'b1; op_count = 32'd2; exp_len = 32'd5;
    tick();
    start = 1'b0; op_count = 32'd9; exp_len = 32'd9;   // a mid-frame change must be ignored
    chk_out("f1.hops", 32'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("f1.hops.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f1.hlen", 32'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("f1.body0", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("f1.body0.rdy", {31'd0, pl_ready}, 32'd1);
    send(2'd1, 30'h10);
    tick();
    chk_out("f1.w1", 32'h4000_0010, 1'b1, 1'b1, 1'b0, 1'b0);
    send(2'd2, 30'h20);
    tick();
    chk_out("f1.w2", 32'h8000_0020, 1'b1, 1'b1, 1'b0, 1'b0);
    send(2'd1, 30'h11);
    tick();
    chk_out("f1.w3", 32'h4000_0011, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("f1.w3.rdy", {31'd0, pl_ready}, 32'd0);
    no_payload();
    tick();
    chk_out("f1.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    chk_out("f1.idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 2: op_count=0 skips the body
    start = 1'b1; op_count = 32'd0; exp_len = 32'd7;
    tick();
    start = 1'b0;
    chk_out("f2.hops", 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("f2.hops.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f2.hlen", 32'd7, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("f2.hlen.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f2.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("f2.done.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f2.idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 3: three starved cycles, then the only operation word
    start = 1'b1; op_count = 32'd1; exp_len = 32'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk_out("f3.body0", 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out($sformatf("f3.wait%0d", i), 32'hC000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    send(2'd1, 30'h3);
    tick();
    chk_out("f3.w1", 32'h4000_0003, 1'b1, 1'b1, 1'b0, 1'b0);
    no_payload();
    tick();
    chk_out("f3.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

    // Frame 4: start during BODY, then a type-0 word; start in DONE
    start = 1'b1; op_count = 32'd1; exp_len = 32'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    send(2'd0, 30'h55);
    tick();
    start = 1'b0;
    chk_out("f4.t0", 32'h0000_0055, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("f4.t0.rdy", {31'd0, pl_ready}, 32'd1);   // the type-0 word did not count
    send(2'd1, 30'h1);
    tick();
    chk_out("f4.w1", 32'h4000_0001, 1'b1, 1'b1, 1'b0, 1'b0);
    no_payload();
    tick();
    chk_out("f4.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("f4.idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Frame 5: reset mid-body, then a normal frame
    start = 1'b1; op_count = 32'd2; exp_len = 32'd4;
    tick();
    start = 1'b0;
    tick();
    tick();
    send(2'd1, 30'h7);
    tick();
    chk_out("f5.w1", 32'h4000_0007, 1'b1, 1'b1, 1'b0, 1'b0);
    clear = 1'b0;
    #1;
    chk("f5.rst.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f5.rst", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    no_payload();
    tick();
    chk_out("f5.post", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; op_count = 32'd1; exp_len = 32'd1;
    tick();
    start = 1'b0;
    chk_out("f5b.hops", 32'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    send(2'd1, 30'h2A);
    tick();
    chk_out("f5b.w1", 32'h4000_002A, 1'b1, 1'b1, 1'b0, 1'b0);
    no_payload();
    tick();
    chk_out("f5b.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();

`ifdef DATA_FRAMER_TIMEOUT_EN
    // Frame 6: timeout abort after four waiting words
    start = 1'b1; op_count = 32'd1; exp_len = 32'd1;
    tick();
    start = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("f6.wait%0d", i), 32'hC000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    chk("f6.rdy", {31'd0, pl_ready}, 32'd0);
    tick();
    chk_out("f6.done", 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk_out("f6.idle", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
